// File: rtl/jam_pkg.sv
// Shared definitions for the JAM worker/job cost table and its monitor.
// Latency: none; this file holds only types, constants and a pure function.
// Backpressure: none.
package jam_pkg;

  localparam int N_WORK = 8;
  localparam int N_JOB  = 8;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 16;
  localparam int TBL_N  = N_WORK * N_JOB;
  localparam int IDX_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  // Row-major table index: worker selects the row, job selects the column.
  function automatic logic [IDX_W-1:0] cost_idx(input logic [2:0] w, input logic [2:0] j);
    return {w, j};
  endfunction

endpackage

// File: rtl/jam_perm_monitor.sv
// Watches the W/J lookup stream and reports each complete W=0..7 window.
// Latency: perm_* outputs are registered, one cycle after the W=7 lookup.
// Backpressure: none; purely observes the stream, never stalls it.
module jam_perm_monitor #(
  parameter int COST_W = jam_pkg::COST_W,
  parameter int SUM_W  = jam_pkg::SUM_W,
  parameter int CNT_W  = jam_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tbl_ready,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  input  logic [COST_W-1:0] Cost,
  output logic              perm_done,
  output logic              perm_err,
  output logic [SUM_W-1:0]  perm_sum,
  output logic [CNT_W-1:0]  perm_count
);
  import jam_pkg::*;

  logic              act_q,  act_d;
  logic [2:0]        exp_q,  exp_d;
  logic [N_JOB-1:0]  mask_q, mask_d;
  logic [SUM_W-1:0]  acc_q,  acc_d;
  logic              done_q, done_d;
  logic              err_q,  err_d;
  logic [SUM_W-1:0]  sum_q,  sum_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [N_JOB-1:0]  j_onehot;
  logic [SUM_W-1:0]  cost_ext;

  assign j_onehot = N_JOB'(1) << J;
  assign cost_ext = SUM_W'(Cost);

  // Window tracking: W=0 always restarts, the expected W advances, anything else abandons.
  always_comb begin
    act_d  = act_q;
    exp_d  = exp_q;
    mask_d = mask_q;
    acc_d  = acc_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    if (!tbl_ready) begin
      act_d = 1'b0;
    end else if (W == 3'd0) begin
      act_d  = 1'b1;
      mask_d = j_onehot;
      acc_d  = cost_ext;
      exp_d  = 3'd1;
    end else if (act_q && (W == exp_q)) begin
      if (W == 3'(N_WORK - 1)) begin
        act_d  = 1'b0;
        done_d = 1'b1;
        err_d  = ((mask_q | j_onehot) != {N_JOB{1'b1}});
        sum_d  = acc_q + cost_ext;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        mask_d = mask_q | j_onehot;
        acc_d  = acc_q + cost_ext;
        exp_d  = exp_q + 3'd1;
      end
    end else begin
      act_d = 1'b0;
    end
  end

  // Register window state and the reported results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      act_q  <= 1'b0;
      exp_q  <= 3'd0;
      mask_q <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      sum_q  <= '0;
      cnt_q  <= '0;
    end else begin
      act_q  <= act_d;
      exp_q  <= exp_d;
      mask_q <= mask_d;
      acc_q  <= acc_d;
      done_q <= done_d;
      err_q  <= err_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
    end
  end

  assign perm_done  = done_q;
  assign perm_err   = err_q;
  assign perm_sum   = sum_q;
  assign perm_count = cnt_q;

endmodule

// File: rtl/jam_cost_table.sv
// JAM cost responder: 8x8 cost table loaded serially, looked up by (W, J).
// Latency: Cost is combinational (zero cycles); perm_* one cycle after W=7.
// Backpressure: ld_ready high until all 64 entries are taken, then low for good.
module jam_cost_table #(
  parameter int COST_W = jam_pkg::COST_W,
  parameter int SUM_W  = jam_pkg::SUM_W,
  parameter int CNT_W  = jam_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              tbl_ready,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              perm_done,
  output logic              perm_err,
  output logic [SUM_W-1:0]  perm_sum,
  output logic [CNT_W-1:0]  perm_count
);
  import jam_pkg::*;

  state_e            state_q;
  logic [IDX_W-1:0]  ld_ptr_q;
  logic              ld_ready_q;
  logic              tbl_ready_q;
  logic [COST_W-1:0] mem_q [TBL_N];
  logic              wr_en;

  // ld_ptr is 0 in IDLE, so one write port serves both IDLE and LOAD.
  assign wr_en = ld_valid && !RST && (state_q != READY);

  // Load sequencer: IDLE -> LOAD -> READY, READY held until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ld_ptr_q    <= '0;
      ld_ready_q  <= 1'b1;
      tbl_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_valid) begin
            ld_ptr_q <= IDX_W'(1);
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            if (ld_ptr_q == IDX_W'(TBL_N - 1)) begin
              state_q     <= READY;
              ld_ready_q  <= 1'b0;
              tbl_ready_q <= 1'b1;
            end else begin
              ld_ptr_q <= ld_ptr_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= READY;
        end
      endcase
    end
  end

  // Table storage: written only while loading, deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[ld_ptr_q] <= ld_data;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign tbl_ready = tbl_ready_q;
  assign Cost      = tbl_ready_q ? mem_q[cost_idx(W, J)] : '0;

  jam_perm_monitor #(
    .COST_W (COST_W),
    .SUM_W  (SUM_W),
    .CNT_W  (CNT_W)
  ) u_mon (
    .CLK        (CLK),
    .RST        (RST),
    .tbl_ready  (tbl_ready_q),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .perm_done  (perm_done),
    .perm_err   (perm_err),
    .perm_sum   (perm_sum),
    .perm_count (perm_count)
  );

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table with a scoreboard of expected windows.
// Latency: checks Cost 1ns after inputs change, registered outputs 1ns after the edge.
// Backpressure: drives ld_valid regardless of ld_ready to probe READY behaviour.
module tb_jam_cost_table;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ld_valid = 1'b0;
  logic [6:0]  ld_data = '0;
  logic        ld_ready;
  logic        tbl_ready;
  logic [2:0]  W = '0;
  logic [2:0]  J = '0;
  logic [6:0]  Cost;
  logic        perm_done;
  logic        perm_err;
  logic [9:0]  perm_sum;
  logic [15:0] perm_count;

  jam_cost_table dut (
    .CLK        (CLK),
    .RST        (RST),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .tbl_ready  (tbl_ready),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .perm_done  (perm_done),
    .perm_err   (perm_err),
    .perm_sum   (perm_sum),
    .perm_count (perm_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        err;
    logic [9:0]  sum;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulses   = 0;
  logic [6:0]  tb_mem [64];
  logic        m_ready = 1'b0;
  logic        m_act   = 1'b0;
  logic [2:0]  m_exp   = '0;
  logic [7:0]  m_mask  = '0;
  logic [9:0]  m_acc   = '0;
  logic [9:0]  m_sum   = '0;
  logic [15:0] m_cnt   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] entry_val(input int mode, input int i);
    logic [6:0] v;
    case (mode)
      0:       v = 7'(i);
      1:       v = 7'((i * 37 + 5) % 128);
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  // Advance one edge and check the registered monitor outputs against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("perm_done", perm_done, 1);
      chk("perm_err", perm_err, e.err);
      chk("perm_sum", perm_sum, e.sum);
      chk("perm_count", perm_count, e.cnt);
      m_sum = e.sum;
    end else begin
      chk("perm_done_idle", perm_done, 0);
      chk("perm_err_idle", perm_err, 0);
      chk("perm_sum_hold", perm_sum, m_sum);
      chk("perm_count_hold", perm_count, m_cnt);
    end
    if (perm_done === 1'b1) pulses++;
  endtask

  // Drive one lookup, check Cost in the same cycle, update the window model.
  task automatic step(input logic [2:0] w, input logic [2:0] j);
    logic [6:0] ec;
    exp_t e;
    W = w;
    J = j;
    #1;
    ec = m_ready ? tb_mem[{w, j}] : 7'd0;
    chk("cost", Cost, ec);
    if (m_ready) begin
      if (w == 3'd0) begin
        m_act  = 1'b1;
        m_mask = 8'd1 << j;
        m_acc  = 10'(ec);
        m_exp  = 3'd1;
      end else if (m_act && w == m_exp) begin
        m_mask = m_mask | (8'd1 << j);
        m_acc  = m_acc + 10'(ec);
        if (w == 3'd7) begin
          m_act = 1'b0;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          e.err = (m_mask != 8'hFF);
          e.sum = m_acc;
          e.cnt = m_cnt;
          sb.push_back(e);
        end else begin
          m_exp = m_exp + 3'd1;
        end
      end else begin
        m_act = 1'b0;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    ld_valid = 1'b0;
    W        = 3'd5;
    J        = 3'd3;
    sb.delete();
    m_ready = 1'b0;
    m_act   = 1'b0;
    m_cnt   = '0;
    m_sum   = '0;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_tbl_ready", tbl_ready, 0);
    chk("rst_cost", Cost, 0);
  endtask

  // Stream n entries (optionally with a bubble every third cycle), checking handshake outputs.
  task automatic load(input int mode, input bit gaps, input int n);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    W   = 3'd5;
    J   = 3'd3;
    while (i < n) begin
      if (gaps && (cyc % 3 == 2)) begin
        ld_valid = 1'b0;
        ld_data  = 7'h55;
      end else begin
        ld_valid  = 1'b1;
        ld_data   = entry_val(mode, i);
        tb_mem[i] = ld_data;
        i++;
      end
      #1;
      chk("load_ld_ready", ld_ready, 1);
      chk("load_tbl_ready", tbl_ready, 0);
      chk("load_cost", Cost, 0);
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    if (n == 64) begin
      m_ready = 1'b1;
      chk("done_tbl_ready", tbl_ready, 1);
      chk("done_ld_ready", ld_ready, 0);
    end
  endtask

  initial begin
    logic [2:0] seq5 [20];
    logic [2:0] brk [7];
    int p0;
    seq5 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
             3'd0, 3'd1, 3'd2, 3'd0,
             3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    brk  = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    // Test 1: reset state, dense load, same-cycle lookup.
    do_reset();
    chk("rst_perm_done", perm_done, 0);
    chk("rst_perm_err", perm_err, 0);
    chk("rst_perm_sum", perm_sum, 0);
    chk("rst_perm_count", perm_count, 0);
    load(0, 1'b0, 64);
    W = 3'd5;
    J = 3'd3;
    #1;
    chk("t1_cost_5_3", Cost, 43);

    // Test 3: identity permutation.
    for (int k = 0; k < 8; k++) step(3'(k), 3'(k));
    chk("t3_done", perm_done, 1);
    chk("t3_err", perm_err, 0);
    chk("t3_sum", perm_sum, 252);
    chk("t3_count", perm_count, 1);
    step(3'd1, 3'd1);
    chk("t3_done_drops", perm_done, 0);

    // Test 4: duplicated job index.
    for (int k = 0; k < 8; k++) step(3'(k), (k == 3 || k == 4) ? 3'd2 : 3'(k));
    chk("t4_done", perm_done, 1);
    chk("t4_err", perm_err, 1);
    chk("t4_sum", perm_sum, 249);
    chk("t4_count", perm_count, 2);

    // Test 5: JAM-style wrap and restart, then a broken window.
    p0 = pulses;
    for (int k = 0; k < 20; k++) step(seq5[k], seq5[k]);
    chk("t5_pulses", pulses - p0, 2);
    chk("t5_count", perm_count, 4);
    p0 = pulses;
    for (int k = 0; k < 7; k++) step(brk[k], brk[k]);
    chk("t5_break_pulses", pulses - p0, 0);
    chk("t5_break_count", perm_count, 4);

    // Test 2: gapped load, full readback, READY ignores further loads.
    do_reset();
    load(1, 1'b1, 64);
    for (int k = 0; k < 64; k++) step(3'(k / 8), 3'(k % 8));
    ld_valid = 1'b1;
    ld_data  = 7'h7F;
    for (int k = 0; k < 3; k++) step(3'd0, 3'd0);
    chk("t2_ld_ready_ready", ld_ready, 0);
    ld_valid = 1'b0;
    W = 3'd0;
    J = 3'd0;
    #1;
    chk("t2_entry00", Cost, 5);

    // Test 6: reset mid-load, reload with all 127, maximum window sum.
    do_reset();
    load(0, 1'b0, 30);
    RST      = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 7'h11;
    tick();
    RST      = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("t6_rst_ld_ready", ld_ready, 1);
    chk("t6_rst_tbl_ready", tbl_ready, 0);
    load(2, 1'b0, 64);
    for (int k = 0; k < 8; k++) step(3'(k), 3'(7 - k));
    chk("t6_done", perm_done, 1);
    chk("t6_err", perm_err, 0);
    chk("t6_sum", perm_sum, 1016);
    chk("t6_count", perm_count, 1);
    step(3'd2, 3'd2);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Responder end of the JAM worker/job cost interface.
- Holds the 8x8 table of 7-bit costs, loaded serially after reset.
- Answers each (W, J) lookup combinationally in the same cycle, which is the timing the JAM initiator uses when it accumulates Cost.
- Also monitors the W/J stream. It flags each complete permutation window with its cost sum and a legality check, so the bench and silicon debug can cross-check MinCost/MatchCount.

Parameters:
- COST_W, 7, width of one cost entry.
- SUM_W, 10, width of the permutation cost sum (8 x 127 = 1016 fits).
- CNT_W, 16, width of the saturating permutation counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- ld_valid  input  1  load entry present on ld_data.
- ld_data  input  COST_W  cost entry; row-major order, index = W*8+J.
- ld_ready  output  1  table accepts a load entry this cycle.
- tbl_ready  output  1  all 64 entries loaded; lookups are valid.
- W  input  3  worker index from the initiator.
- J  input  3  job index from the initiator.
- Cost  output  COST_W  table[W][J] when tbl_ready, else 0; combinational.
- perm_done  output  1  one-cycle pulse: a W=0..7 window just completed.
- perm_err  output  1  valid with perm_done: J values in the window were not all distinct.
- perm_sum  output  SUM_W  sum of the 8 costs of the last completed window; held until the next perm_done.
- perm_count  output  CNT_W  number of perm_done pulses since reset; saturates at all-ones.

Behaviour:
- Reset values (RST=1 at an edge): state=IDLE, ld_ptr=0, ld_ready=1, tbl_ready=0, perm_done=0, perm_err=0, perm_sum=0, perm_count=0, window inactive.
- Table contents are not reset.
- Reset mid-load or mid-window aborts everything. The load restarts at index 0.
- FSM states: IDLE, LOAD, READY.
  - IDLE: ld_ready=1. On ld_valid, write entry 0, set ld_ptr=1, go to LOAD.
  - LOAD: ld_ready=1. Each cycle with ld_valid, write table[ld_ptr] and increment ld_ptr. A gap in ld_valid stalls with no write.
  - LOAD exit: the write at ld_ptr=63 goes to READY. tbl_ready=1 and ld_ready=0 take effect from the next cycle.
  - READY: terminal until RST. ld_valid is ignored and the table is never overwritten.
- ld_ptr is 6 bits: W=ptr[5:3], J=ptr[2:0]. No wrap can occur because exit happens at 63.
- Lookup: Cost is a pure combinational read with zero latency.
  - Cost=0 whenever tbl_ready=0, including the cycle the last entry is written.
- Monitor (active only when tbl_ready=1):
  - W==0 in any cycle (re)starts the window: jmask=onehot(J), acc=Cost, expected next W=1. A repeated W=0 restarts the window.
  - W==expected (1..7): jmask|=onehot(J), acc+=Cost (SUM_W bits, no overflow possible), expected++.
  - Any other W (not 0, not expected): window is abandoned silently. No pulse, no error.
  - Accepted W==7 step: next cycle perm_done=1, perm_err=(jmask incl. this J != 8'hFF), perm_sum=acc incl. this Cost, perm_count++ unless all-ones. Window then goes inactive.
  - perm_done is deasserted in every other cycle. perm_err is only meaningful while perm_done=1 and is driven 0 otherwise.
  - Initiator wrap patterns (W=0,1,2 then W=0 again) restart cleanly with no spurious pulse.

Decomposition:
- Shared package jam_pkg: N_WORK=8, N_JOB=8, COST_W, SUM_W, the FSM state enum (IDLE/LOAD/READY), and the row-major index function.
- One sub-module, jam_perm_monitor. It takes W, J, Cost and tbl_ready and produces perm_done/perm_err/perm_sum/perm_count.
- The table plus load FSM stays in the top.

Test Plan:
1. Reset, then load 64 entries with table[w][j]=w*8+j, one per cycle -> ld_ready falls and tbl_ready rises the cycle after entry 63. W=5, J=3 -> Cost=43 the same cycle.
2. Load with ld_valid gaps every third cycle -> exactly 64 writes; the readback of all 64 entries matches; extra ld_valid pulses in READY leave table[0][0] unchanged.
3. Table as in 1; drive W=0..7 with J=0..7 on consecutive cycles -> perm_done one cycle after W=7, perm_err=0, perm_sum=252, perm_count=1.
4. Same sequence but J=2 at both W=3 and W=4 -> perm_done=1, perm_err=1, perm_count=2.
5. Drive the JAM-style pattern W=0..7,0,1,2,0,0..7 -> exactly one pulse per complete 0..7 run. A W=0,1,3 break gives no pulse.
6. Assert RST at load index 30, then reload with all entries=127 -> tbl_ready only after 64 fresh writes. A full window then gives perm_sum=1016 and perm_count restarts from 1.
